vic_reg_loader: RTL

- Write sequencer in front of the VIC register file.
- Accepts register-write requests from a host through a valid/ready handshake, buffers them in a small FIFO, and replays each one onto the register file's address/data/write-enable port with fixed setup/strobe/hold timing.
- On a commit request it drains the queue, writes the enable register (address 31, value 4'hF) and waits for the register file's enable flag, reporting done or timeout.

---
 rtl/vic_reg_loader_pkg.sv | 32 +++
 rtl/vic_reg_loader_fifo.sv | 63 ++++++
 rtl/vic_reg_loader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/vic_reg_loader_pkg.sv
// Shared definitions for the VIC register-file write sequencer.
// Holds register-file geometry, the enable-register address/value,
// the sequencer FSM encoding and the queued request entry layout.
package vic_reg_loader_pkg;

  localparam int VIC_ADDR_W = 5;
  localparam int VIC_DATA_W = 4;

  // Writing this value to this address arms the register file.
  localparam logic [VIC_ADDR_W-1:0] VIC_EN_ADDR = 5'd31;
  localparam logic [VIC_DATA_W-1:0] VIC_EN_VAL  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_WAIT_EN = 3'd4
  } vic_state_e;

  typedef struct packed {
    logic [VIC_ADDR_W-1:0] addr;
    logic [VIC_DATA_W-1:0] data;
  } vic_req_t;

  function automatic int vic_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/vic_reg_loader_fifo.sv
// Purpose: synchronous FIFO of (addr, data) register-write requests.
// Latency: a pushed entry is visible at the head on the cycle after the push edge.
// Backpressure: pushes are dropped while full, even on an edge that also pops.
// Ports: clk/rst; push_i + push_addr_i/push_data_i; pop_i; pop_addr_o/pop_data_o
//        show the head entry; full_o/empty_o/count_o report occupancy.
module vic_req_fifo
  import vic_reg_loader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [VIC_ADDR_W-1:0] push_addr_i,
  input  logic [VIC_DATA_W-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [VIC_ADDR_W-1:0] pop_addr_o,
  output logic [VIC_DATA_W-1:0] pop_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  vic_req_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  // Full is judged before the edge, so a same-edge pop cannot make room.
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_addr_o = mem_q[rd_ptr_q].addr;
  assign pop_data_o = mem_q[rd_ptr_q].data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= '{addr: push_addr_i, data: push_data_i};
        wr_ptr_q        <= wr_ptr_q + 1'b1;  // DEPTH is a power of two: natural wrap
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vic_reg_loader.sv
// Purpose: queues host register writes and replays them onto the VIC register file
//          with setup/strobe/hold timing; a commit writes reg 31 = F and awaits enable.
// Latency: request accepted at E0 (idle, empty) pops at E0+1, strobes at E0+1+SETUP_CYCLES.
// Backpressure: o_req_ready = !full; a full queue stalls the host until the next pop.
// Ports: host side i_req_valid/o_req_ready/i_req_addr/i_req_data/i_commit;
//        register-file side o_VIC_regaddr/o_VIC_data/o_VIC_we/i_VIC_enable;
//        status o_busy, o_done (pulse), o_error (sticky timeout).
module vic_reg_loader
  import vic_reg_loader_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int SETUP_CYCLES = 1,
  parameter int HOLD_CYCLES  = 1,
  parameter int EN_TIMEOUT   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [VIC_ADDR_W-1:0] i_req_addr,
  input  logic [VIC_DATA_W-1:0] i_req_data,
  input  logic                  i_commit,
  output logic [VIC_ADDR_W-1:0] o_VIC_regaddr,
  output logic [VIC_DATA_W-1:0] o_VIC_data,
  output logic                  o_VIC_we,
  input  logic                  i_VIC_enable,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  localparam int CNT_MAX = vic_max3(SETUP_CYCLES, HOLD_CYCLES, EN_TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic                       fifo_full;
  logic                       fifo_empty;
  logic [VIC_ADDR_W-1:0]      head_addr;
  logic [VIC_DATA_W-1:0]      head_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  vic_state_e            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [VIC_ADDR_W-1:0] addr_q;
  logic [VIC_DATA_W-1:0] data_q;
  logic                  we_q;
  logic                  commit_wr_q;
  logic                  pend_q;
  logic                  pend_d;
  logic                  done_q;
  logic                  error_q;

  logic hold_last;
  logic dispatch;
  logic do_pop;
  logic do_commit;

  vic_req_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (i_req_valid),
    .push_addr_i(i_req_addr),
    .push_data_i(i_req_data),
    .pop_i      (do_pop),
    .pop_addr_o (head_addr),
    .pop_data_o (head_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign hold_last = (state_q == ST_HOLD) && (cnt_q == CNT_W'(HOLD_CYCLES - 1));
  // The last HOLD cycle of a plain write dispatches the next job directly,
  // so back-to-back writes cost SETUP+1+HOLD cycles with no idle gap.
  assign dispatch  = (state_q == ST_IDLE) || (hold_last && !commit_wr_q);
  assign do_pop    = dispatch && !fifo_empty;
  assign do_commit = dispatch && fifo_empty && pend_q;
  // A pulse on the load edge itself is a new request and stays pending.
  assign pend_d    = i_commit || (pend_q && !do_commit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      commit_wr_q <= 1'b0;
      pend_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      pend_q <= pend_d;
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (do_pop) begin
        addr_q      <= head_addr;
        data_q      <= head_data;
        commit_wr_q <= 1'b0;
        cnt_q       <= '0;
        state_q     <= ST_SETUP;
      end else if (do_commit) begin
        addr_q      <= VIC_EN_ADDR;
        data_q      <= VIC_EN_VAL;
        commit_wr_q <= 1'b1;
        error_q     <= 1'b0;
        cnt_q       <= '0;
        state_q     <= ST_SETUP;
      end else begin
        case (state_q)
          ST_SETUP: begin
            if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
              we_q    <= 1'b1;
              state_q <= ST_STROBE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_STROBE: begin
            cnt_q   <= '0;
            state_q <= ST_HOLD;
          end
          ST_HOLD: begin
            if (hold_last) begin
              cnt_q   <= '0;
              state_q <= commit_wr_q ? ST_WAIT_EN : ST_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_WAIT_EN: begin
            if (i_VIC_enable) begin
              done_q  <= 1'b1;
              error_q <= 1'b0;
              state_q <= ST_IDLE;
            end else if (cnt_q == CNT_W'(EN_TIMEOUT - 1)) begin
              error_q <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_req_ready   = !fifo_full;
  assign o_VIC_regaddr = addr_q;
  assign o_VIC_data    = data_q;
  assign o_VIC_we      = we_q;
  assign o_done        = done_q;
  assign o_error       = error_q;
  assign o_busy        = (state_q != ST_IDLE) || (fifo_count != '0) || pend_q;

endmodule
